spi_rx_capture: RTL and testbench
=================================

# spi_rx_capture

Receive-side capture stage for the SPI master. It oversamples the `sclk`, `cs` and `miso` pins in the 100 MHz `clk` domain and deserializes MISO MSB-first on each SCLK rising edge while the FSM's `receive` window is open. Completed bytes are buffered in a small FIFO with a first-byte-of-window tag and handed to downstream sample-processing logic over a valid/ready stream.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `SYNC_STAGES`, 2: synchronizer flops on `sclk_in`, `cs_in` and `miso`; ≥2.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: reset, asynchronous, active-low.
- `sclk_in` in 1: SPI serial clock, asynchronous to `clk`; at most `clk`/4.
- `cs_in` in 1: chip select, active low.
- `miso` in 1: serial data from the slave.
- `rx_en` in 1: receive window from the FSM `receive` output; level.
- `rx_data` out 8: head-of-FIFO byte.
- `rx_first` out 1: head byte is the first byte of its window.
- `rx_valid` out 1: head entry present.
- `rx_ready` in 1: consumer accepts the head when `rx_valid && rx_ready`.
- `level` out $clog2(DEPTH)+1: FIFO occupancy, 0..DEPTH.
- `overflow` out 1: sticky; a completed byte was dropped.
- `ovf_clr` in 1: clears `overflow`.

## Operation
- Pins pass through `SYNC_STAGES` flops. Equal-length chains keep `sclk`, `cs` and `miso` aligned.
- Edge detect: `rise = sclk_s & ~sclk_q`, where `sclk_q` is `sclk_s` delayed one more cycle.
- `active = rx_en & ~cs_s`.
- FSM states are IDLE and SHIFT.
  - IDLE: `bit_cnt=0`, `first_pend=1`. Go to SHIFT when `active`.
  - SHIFT: on `rise`, `shreg <= {shreg[6:0], miso_s}` and `bit_cnt++`.
  - On the `rise` that completes bit 7, push `{first_pend, byte}`, clear `first_pend`, set `bit_cnt=0`, stay in SHIFT.
  - In SHIFT, `!active` discards any partial byte and returns to IDLE. No push.
- `rise` in the same cycle that `active` rises is not sampled, because the FSM is still in IDLE.
- Push when the FIFO is full: the byte is dropped and `overflow` is set. Fullness is evaluated before a same-cycle pop, so a byte arriving while full is dropped even if the consumer pops that cycle.
- Pop occurs when `rx_valid && rx_ready`. A pop on empty has no effect.
- Push and pop in the same cycle when not full and not empty: `level` is unchanged.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. Full is `level==DEPTH`.
- If a byte is dropped with its first flag set, the next stored byte does not inherit the flag.
- `overflow` set has priority over `ovf_clr` in the same cycle.

## Timing
- Reset values:
  - `rx_data=8'h00`, `rx_first=0`, `rx_valid=0`, `level=0`, `overflow=0`.
  - FSM in IDLE, `shreg=0`, pointers 0, synchronizers 0.
- Pin SCLK rise to `rise` pulse: `SYNC_STAGES+1` `clk` cycles.
- Push cycle to `rx_valid`/`rx_data` visible: 1 cycle. Outputs are registered, taken from FIFO head storage.
- Pop: the next head (or `rx_valid=0`) is presented on the following cycle.
- Full-rate throughput: one byte per 8 SCLK periods, i.e. 160 `clk` cycles at 5 MHz.
- Reset mid-byte aborts immediately and all state returns to reset values. The first full byte after reset release carries `rx_first=1`.
- MISO timing: MISO must be stable for ≥`SYNC_STAGES+1` cycles around the SCLK rising edge. At 5 MHz, the slave changes MISO on the falling edge, which gives 10-cycle margin.

## Structure
- Shared package `spi_pkg`:
  - `rx_state_t` enum {IDLE, SHIFT}.
  - `SPI_BYTE_W = 8`.
  - `rx_entry_t` packed struct {first, data[7:0]}.
- Sub-module `sync_fifo` (parameterized width/depth; registered head output; `level`, full/empty). Synchronizers and FSM stay inline.

## Test plan
- Reset, then `rx_en=1`, `cs_in=0`, drive MISO bytes 0xAD then 0x5A at 5 MHz → two entries: {first=1, 0xAD}, {first=0, 0x5A}. `level` reaches 2 with `rx_ready=0`.
- Deassert `cs_in` after 5 bits, then send a full byte 0x3C → only 0x3C is stored, with `rx_first=1`. The partial byte is never pushed.
- `DEPTH=4`, `rx_ready=0`, send 5 bytes 0x01..0x05 → `level=4`, `overflow=1`, FIFO holds 0x01..0x04. Pulse `ovf_clr` → `overflow=0`.
- FIFO full, `rx_ready=1` in the exact push cycle of a 5th byte → byte dropped, `overflow=1`, `level=3` next cycle.
- Hold `rx_ready=1` for a continuous 12-byte stream 0x10..0x1B → all 12 bytes delivered in order, `level` ≤1, `overflow=0`, only the first byte has `rx_first=1`.
- Assert `rst` low mid-byte with 2 entries queued → `rx_valid=0` and `level=0` without waiting for a clock edge. The post-reset byte 0xC3 arrives with `rx_first=1`.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master receive path.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

    typedef struct packed {
        logic                  first;
        logic [SPI_BYTE_W-1:0] data;
    } rx_entry_t;

    localparam int RX_ENTRY_W = $bits(rx_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head output, occupancy count and full flag.
// A push while full is ignored here; the caller decides what a drop means.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       head_valid,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic             push_ok;
    logic             pop_ok;

    assign full       = (level_q == LVL_W'(DEPTH));
    assign head_data  = head_q;
    assign head_valid = valid_q;
    assign level      = level_q;

    // Fullness is judged on the current level, so a push into a full FIFO is
    // refused even if the head is popped in the same cycle.
    always_comb begin
        push_ok  = push & ~full;
        pop_ok   = pop & (level_q != '0);

        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        level_d  = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);

        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
        end

        // Reading the next head from mem_d covers a push into an empty or
        // just-emptied FIFO without a separate bypass path.
        head_d  = head_q;
        valid_d = (level_d != '0);
        if (level_d != '0) begin
            head_d = mem_d[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: rtl/spi_rx_capture.sv
// SPI receive capture: synchronizes the pins, deserializes MISO MSB-first on
// SCLK rising edges inside the receive window, and queues tagged bytes.
module spi_rx_capture
    import spi_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sclk_in,
    input  logic                     cs_in,
    input  logic                     miso,
    input  logic                     rx_en,
    output logic [7:0]               rx_data,
    output logic                     rx_first,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] miso_sync_q, miso_sync_d;
    logic                   sclk_dly_q, sclk_dly_d;

    logic sclk_s;
    logic cs_s;
    logic miso_s;
    logic rise;
    logic active;

    rx_state_t             state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic                  first_pend_q, first_pend_d;
    logic [SPI_BYTE_W-2:0] shreg_q, shreg_d;
    logic                  overflow_q, overflow_d;

    logic                  push;
    rx_entry_t             push_entry;
    rx_entry_t             head_entry;
    logic [RX_ENTRY_W-1:0] push_bits;
    logic [RX_ENTRY_W-1:0] head_bits;
    logic                  fifo_full;

    // All three pins share one chain length so their relative timing survives.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_in};
        miso_sync_d = {miso_sync_q[SYNC_STAGES-2:0], miso};
        sclk_dly_d  = sclk_sync_q[SYNC_STAGES-1];
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign miso_s = miso_sync_q[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_dly_q;
    assign active = rx_en & ~cs_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            miso_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            miso_sync_q <= miso_sync_d;
            sclk_dly_q  <= sclk_dly_d;
        end
    end

    // Only seven bits are held; the eighth comes straight from miso_s on the
    // completing edge, so the byte is pushed in the same cycle it finishes.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        first_pend_d = first_pend_q;
        shreg_d      = shreg_q;
        push         = 1'b0;
        push_entry   = '{first: first_pend_q, data: {shreg_q, miso_s}};

        case (state_q)
            IDLE: begin
                bit_cnt_d    = 3'd0;
                first_pend_d = 1'b1;
                if (active) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!active) begin
                    state_d   = IDLE;
                    bit_cnt_d = 3'd0;
                end else if (rise) begin
                    shreg_d = {shreg_q[SPI_BYTE_W-3:0], miso_s};
                    if (bit_cnt_q == 3'd7) begin
                        push         = 1'b1;
                        first_pend_d = 1'b0;
                        bit_cnt_d    = 3'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The first tag is consumed even when its byte is dropped.
    always_comb begin
        overflow_d = overflow_q;
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end
        if (push && fifo_full) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            first_pend_q <= 1'b1;
            shreg_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            first_pend_q <= first_pend_d;
            shreg_q      <= shreg_d;
            overflow_q   <= overflow_d;
        end
    end

    assign push_bits  = push_entry;
    assign head_entry = head_bits;

    sync_fifo #(
        .WIDTH (RX_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_bits),
        .pop        (rx_ready),
        .head_data  (head_bits),
        .head_valid (rx_valid),
        .level      (level),
        .full       (fifo_full)
    );

    assign rx_data  = head_entry.data;
    assign rx_first = head_entry.first;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_spi_rx_capture.sv
// Self-checking bench for spi_rx_capture against a queue-based model of
// windows, first tags, FIFO capacity and overflow.
module tb_spi_rx_capture;

    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk_in;
    logic       cs_in;
    logic       miso;
    logic       rx_en;
    logic [7:0] rx_data;
    logic       rx_first;
    logic       rx_valid;
    logic       rx_ready;
    logic [2:0] level;
    logic       overflow;
    logic       ovf_clr;

    int checks = 0;
    int passes = 0;

    logic [8:0] exp_q[$];
    bit         model_first;
    bit         model_ovf;

    spi_rx_capture #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .rst      (rst_n),
        .sclk_in  (sclk_in),
        .cs_in    (cs_in),
        .miso     (miso),
        .rx_en    (rx_en),
        .rx_data  (rx_data),
        .rx_first (rx_first),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .level    (level),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_byte(input logic [7:0] b);
        if (exp_q.size() >= DEPTH) begin
            model_ovf = 1'b1;
        end else begin
            exp_q.push_back({model_first, b});
        end
        model_first = 1'b0;
    endtask

    // 5 MHz mode-0 slave: MISO changes with SCLK falling, 10 clk per half period.
    task automatic send_bits(input logic [7:0] b, input int nbits, input bit pop_at_push);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            sclk_in = 1'b0;
            miso    = b[7-i];
            repeat (10) @(negedge clk);
            sclk_in = 1'b1;
            if (pop_at_push && i == 7) begin
                repeat (SYNC_STAGES) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
            repeat (9) @(negedge clk);
        end
    endtask

    task automatic open_window();
        @(negedge clk);
        sclk_in     = 1'b0;
        cs_in       = 1'b0;
        rx_en       = 1'b1;
        model_first = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic close_window();
        @(negedge clk);
        sclk_in = 1'b0;
        if ($urandom_range(0, 1) == 1) cs_in = 1'b1;
        else rx_en = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic clear_ovf();
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr   = 1'b0;
        model_ovf = 1'b0;
    endtask

    task automatic drain(input string name);
        int n0;
        int got;
        logic [8:0] e;
        n0  = exp_q.size();
        got = 0;
        @(negedge clk);
        rx_ready = 1'b1;
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (rx_valid === 1'b1) begin
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    $display("[TB] FAIL %s extra entry: got %h expected none", name, {rx_first, rx_data});
                end else begin
                    e = exp_q.pop_front();
                    if ({rx_first, rx_data} !== e)
                        $display("[TB] FAIL %s entry: got %h expected %h", name, {rx_first, rx_data}, e);
                    else passes++;
                end
            end
            @(negedge clk);
        end
        rx_ready = 1'b0;
        checks++;
        if (got != n0) $display("[TB] FAIL %s count: got %0d expected %0d", name, got, n0);
        else passes++;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sclk_in = 1'b0; cs_in = 1'b1; miso = 1'b0;
        rx_en = 1'b0; rx_ready = 1'b0; ovf_clr = 1'b0;
        exp_q.delete(); model_first = 1'b1; model_ovf = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rx_valid !== 1'b0) $display("[TB] FAIL reset rx_valid: got %b expected 0", rx_valid); else passes++;
        checks++; if (level !== 3'd0) $display("[TB] FAIL reset level: got %0d expected 0", level); else passes++;
        checks++; if (overflow !== 1'b0) $display("[TB] FAIL reset overflow: got %b expected 0", overflow); else passes++;
        checks++; if (rx_data !== 8'h00) $display("[TB] FAIL reset rx_data: got %h expected 00", rx_data); else passes++;
        checks++; if (rx_first !== 1'b0) $display("[TB] FAIL reset rx_first: got %b expected 0", rx_first); else passes++;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_two_bytes();
        open_window();
        send_bits(8'hAD, 8, 1'b0); model_byte(8'hAD);
        send_bits(8'h5A, 8, 1'b0); model_byte(8'h5A);
        repeat (4) @(negedge clk);
        checks++;
        if (level !== 3'(exp_q.size())) $display("[TB] FAIL two_bytes level: got %0d expected %0d", level, exp_q.size());
        else passes++;
        close_window();
        drain("two_bytes");
    endtask

    task automatic test_partial_abort();
        open_window();
        send_bits(8'($urandom), 5, 1'b0);
        close_window();
        open_window();
        send_bits(8'h3C, 8, 1'b0); model_byte(8'h3C);
        close_window();
        checks++;
        if (level !== 3'(exp_q.size())) $display("[TB] FAIL partial level: got %0d expected %0d", level, exp_q.size());
        else passes++;
        drain("partial");
    endtask

    task automatic test_overflow();
        open_window();
        for (int b = 1; b <= 5; b++) begin
            send_bits(8'(b), 8, 1'b0);
            model_byte(8'(b));
        end
        close_window();
        checks++;
        if (level !== 3'(exp_q.size())) $display("[TB] FAIL ovf level: got %0d expected %0d", level, exp_q.size());
        else passes++;
        checks++;
        if (overflow !== model_ovf) $display("[TB] FAIL ovf set: got %b expected %b", overflow, model_ovf);
        else passes++;
        clear_ovf();
        @(negedge clk);
        checks++;
        if (overflow !== model_ovf) $display("[TB] FAIL ovf clear: got %b expected %b", overflow, model_ovf);
        else passes++;
        drain("ovf");
    endtask

    task automatic test_full_pop();
        logic [7:0] b;
        logic [8:0] popped;
        open_window();
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            send_bits(b, 8, 1'b0);
            model_byte(b);
        end
        b = 8'($urandom);
        send_bits(b, 8, 1'b1);
        model_byte(b);
        popped = exp_q.pop_front();
        close_window();
        checks++;
        if (level !== 3'(exp_q.size())) $display("[TB] FAIL full_pop level: got %0d expected %0d (popped %h)", level, exp_q.size(), popped);
        else passes++;
        checks++;
        if (overflow !== model_ovf) $display("[TB] FAIL full_pop overflow: got %b expected %b", overflow, model_ovf);
        else passes++;
        drain("full_pop");
        clear_ovf();
    endtask

    task automatic test_stream();
        logic [8:0] got_q[$];
        logic [8:0] want;
        int max_level;
        bit mon_stop;
        mon_stop  = 1'b0;
        max_level = 0;
        @(negedge clk);
        rx_ready = 1'b1;
        open_window();
        fork
            begin
                for (int i = 0; i < 12; i++) send_bits(8'h10 + 8'(i), 8, 1'b0);
                repeat (10) @(negedge clk);
                mon_stop = 1'b1;
            end
            begin
                while (!mon_stop) begin
                    @(negedge clk);
                    if (int'(level) > max_level) max_level = int'(level);
                    if (rx_valid === 1'b1) got_q.push_back({rx_first, rx_data});
                end
            end
        join
        close_window();
        rx_ready = 1'b0;
        checks++;
        if (got_q.size() != 12) $display("[TB] FAIL stream count: got %0d expected 12", got_q.size());
        else passes++;
        for (int i = 0; i < 12 && i < got_q.size(); i++) begin
            want = {(i == 0), 8'h10 + 8'(i)};
            checks++;
            if (got_q[i] !== want) $display("[TB] FAIL stream byte %0d: got %h expected %h", i, got_q[i], want);
            else passes++;
        end
        checks++;
        if (max_level > 1) $display("[TB] FAIL stream level: got max %0d expected <=1", max_level);
        else passes++;
        checks++;
        if (overflow !== 1'b0) $display("[TB] FAIL stream overflow: got %b expected 0", overflow);
        else passes++;
    endtask

    task automatic test_random();
        logic [7:0] b;
        int nb;
        int part;
        for (int w = 0; w < 4; w++) begin
            open_window();
            nb = $urandom_range(1, 6);
            for (int i = 0; i < nb; i++) begin
                b = 8'($urandom);
                send_bits(b, 8, 1'b0);
                model_byte(b);
            end
            part = $urandom_range(0, 7);
            if (part > 0) send_bits(8'($urandom), part, 1'b0);
            close_window();
            checks++;
            if (level !== 3'(exp_q.size())) $display("[TB] FAIL random w%0d level: got %0d expected %0d", w, level, exp_q.size());
            else passes++;
            checks++;
            if (overflow !== model_ovf) $display("[TB] FAIL random w%0d overflow: got %b expected %b", w, overflow, model_ovf);
            else passes++;
            drain("random");
            clear_ovf();
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        open_window();
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            send_bits(b, 8, 1'b0);
            model_byte(b);
        end
        send_bits(8'($urandom), 4, 1'b0);
        @(negedge clk);
        #3 rst_n = 1'b0;
        exp_q.delete(); model_ovf = 1'b0;
        #1;
        checks++;
        if (rx_valid !== 1'b0) $display("[TB] FAIL async reset rx_valid: got %b expected 0", rx_valid);
        else passes++;
        checks++;
        if (level !== 3'(exp_q.size())) $display("[TB] FAIL async reset level: got %0d expected %0d", level, exp_q.size());
        else passes++;
        sclk_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_first = 1'b1;
        repeat (8) @(negedge clk);
        send_bits(8'hC3, 8, 1'b0);
        model_byte(8'hC3);
        repeat (4) @(negedge clk);
        checks++;
        if (level !== 3'(exp_q.size())) $display("[TB] FAIL post reset level: got %0d expected %0d", level, exp_q.size());
        else passes++;
        close_window();
        drain("post_reset");
    endtask

    initial begin
        test_reset();
        test_two_bytes();
        test_partial_abort();
        test_overflow();
        test_full_pop();
        test_stream();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
